// File: rtl/mem_iface_pkg.sv
// Shared constants and FSM state type for the mem_iface CPU-to-RAM bridge.
package mem_iface_pkg;

    localparam int unsigned ADDR_W             = 8;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETUP   = 2'b01,
        ACCESS  = 2'b10,
        RELEASE = 2'b11
    } state_t;

endpackage

// File: rtl/mem_iface_mfc.sv
// mfc_sync: two-flop synchronizer bringing the asynchronous RAM MFC into the CLK domain.
module mfc_sync (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/mem_iface.sv
// mem_iface: CPU-to-RAM handshake bridge (IDLE/SETUP/ACCESS/RELEASE) driven by a synchronized MFC.
// Define MEM_IFACE_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without MFC.
module mem_iface
    import mem_iface_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] MAR,
    output logic              enable,
    output logic              rnw,
    output logic [DATA_W-1:0] bus,
    input  logic [DATA_W-1:0] MBR,
    input  logic              MFC
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_iface: TIMEOUT_CYCLES must be within 1..255");
    end

    state_t state, state_next;
    logic   mfc_s;
    logic   capture, start_access, complete, timeout;

    mfc_sync u_mfc_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (MFC),
        .sync_out (mfc_s)
    );

`ifdef MEM_IFACE_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt;

    // tmo_cnt holds the ACCESS cycles already completed; abort on the edge that would make it TMO_LIMIT.
    always_ff @(posedge CLK) begin
        if (RST)                  tmo_cnt <= '0;
        else if (start_access)    tmo_cnt <= '0;
        else if (state == ACCESS) tmo_cnt <= tmo_cnt + 8'd1;
    end

    assign timeout = (state == ACCESS) && !mfc_s && (tmo_cnt + 8'd1 == TMO_LIMIT);

    always_ff @(posedge CLK) begin
        if (RST) err <= 1'b0;
        else     err <= timeout;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        capture      = 1'b0;
        start_access = 1'b0;
        complete     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture    = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (!mfc_s) begin
                    start_access = 1'b1;
                    state_next   = ACCESS;
                end
            end
            ACCESS: begin
                if (mfc_s) begin
                    complete   = 1'b1;
                    state_next = RELEASE;
                end else if (timeout) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!mfc_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            MAR    <= '0;
            bus    <= '0;
            rnw    <= 1'b1;
            rdata  <= '0;
            enable <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= complete | timeout;
            if (capture) begin
                MAR <= addr;
                bus <= wdata;
                rnw <= ~wr;
            end
            if (start_access)             enable <= 1'b1;
            else if (complete | timeout)  enable <= 1'b0;
            if (complete && rnw)          rdata  <= MBR;
        end
    end

    assign busy = (state != IDLE);

endmodule
